// File: rtl/gat_pkg.sv
// gat_pkg: shared scheduler state encoding and per-layer word-count helpers.
package gat_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, RUN, DRAIN, RELOAD, DONE} sched_state_t;
  localparam int unsigned DEF_SUBGRAPHS = 2708;
  localparam int unsigned DEF_FEATURE_OUT = 16;
  localparam int unsigned DEF_FEATURE_FINAL = 7;
  localparam int unsigned WORDS_L0 = DEF_SUBGRAPHS * DEF_FEATURE_OUT;
  localparam int unsigned WORDS_L1 = DEF_SUBGRAPHS * DEF_FEATURE_FINAL;
  function automatic int unsigned layer_words(input logic layer, input int unsigned nsub,
                                              input int unsigned nout, input int unsigned nfin);
    return nsub * (layer ? nfin : nout);
  endfunction
endpackage

// File: rtl/gat_feat_fifo.sv
// gat_feat_fifo: small output FIFO absorbing BRAM read returns under stream backpressure.
module gat_feat_fifo #(
  parameter int DEPTH = 3,
  parameter int W = 32,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? nxt(wr_q) : wr_q;
    rd_d = pop ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/gat_layer_scheduler.sv
// gat_layer_scheduler: sequences load gating, two GAT layers, feature readback streaming
// and the inter-layer weight reload handshake.
module gat_layer_scheduler import gat_pkg::*; #(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_SUBGRAPHS = DEF_SUBGRAPHS,
  parameter int NUM_FEATURE_OUT = DEF_FEATURE_OUT,
  parameter int NUM_FEATURE_FINAL = DEF_FEATURE_FINAL,
  parameter int RD_LAT = 2,
  parameter int TIMEOUT_W = 24,
  parameter int FEAT_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         h_data_bram_load_done,
  input  logic                         h_node_info_bram_load_done,
  input  logic                         wgt_bram_load_done,
  output logic                         core_h_data_load_done,
  output logic                         core_h_node_info_load_done,
  output logic                         core_wgt_load_done,
  output logic                         gat_layer,
  input  logic                         gat_ready,
  output logic [FEAT_ADDR_W-1:0]       feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0] feat_tdata,
  output logic                         feat_tvalid,
  input  logic                         feat_tready,
  output logic                         feat_tlast,
  output logic                         wgt_reload_req,
  output logic                         sched_busy,
  output logic                         sched_done,
  output logic                         sched_timeout,
  output logic                         sched_layer
);
  localparam int unsigned N0 = layer_words(1'b0, NUM_SUBGRAPHS, NUM_FEATURE_OUT, NUM_FEATURE_FINAL);
  localparam int unsigned N1 = layer_words(1'b1, NUM_SUBGRAPHS, NUM_FEATURE_OUT, NUM_FEATURE_FINAL);
  localparam int CW = $clog2(RD_LAT + 2);
  localparam int OW = $clog2(2 * RD_LAT + 2);
  sched_state_t state_q, state_d;
  logic gat_layer_q, gat_layer_d, timeout_q, timeout_d;
  logic [2:0] core_q, core_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [FEAT_ADDR_W-1:0] rd_addr_q, rd_addr_d, out_cnt_q, out_cnt_d, n_last;
  logic rd_done_q, rd_done_d, seen_fall_q, seen_fall_d, wgt_prev_q, wgt_prev_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [OW-1:0] inflight, occ;
  logic [CW-1:0] fifo_cnt;
  logic [NEW_FEATURE_WIDTH-1:0] fifo_dout;
  logic fifo_empty, pop, issue, last, all_loaded, rise;
  assign all_loaded = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done;
  assign n_last = gat_layer_q ? FEAT_ADDR_W'(N1 - 1) : FEAT_ADDR_W'(N0 - 1);
  assign pop = ~fifo_empty & feat_tready;
  assign last = out_cnt_q == n_last;
  assign rise = seen_fall_q & ~wgt_prev_q & wgt_bram_load_done;
  // Occupancy net of this cycle's pop keeps the pipe full at one word per cycle.
  assign occ = inflight + OW'(fifo_cnt) - OW'(pop);
  assign issue = (state_q == DRAIN) & ~rd_done_q & (occ < OW'(RD_LAT + 1));
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OW'(vld_q[i]);
  end
  always_comb begin
    state_d = state_q;
    gat_layer_d = gat_layer_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WAIT_LOAD;
        gat_layer_d = 1'b0;
        timeout_d = 1'b0;
      end
      WAIT_LOAD: if (all_loaded) state_d = RUN;
      RUN: if (gat_ready) state_d = DRAIN;
        else if (&wdog_q) begin
          state_d = DONE;
          timeout_d = 1'b1;
        end
      DRAIN: if (pop & last) state_d = gat_layer_q ? DONE : RELOAD;
      RELOAD: if (rise) begin
        state_d = RUN;
        gat_layer_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    core_d = (state_d == RUN || state_d == DRAIN) ?
             {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done} : 3'b000;
    wdog_d = (state_q == RUN) ? wdog_q + TIMEOUT_W'(~&wdog_q) : '0;
    rd_addr_d = (state_q == DRAIN) ? rd_addr_q + FEAT_ADDR_W'(issue) : '0;
    rd_done_d = (state_q == DRAIN) & (rd_done_q | (issue & (rd_addr_q == n_last)));
    out_cnt_d = (state_q == DRAIN) ? out_cnt_q + FEAT_ADDR_W'(pop) : '0;
    vld_d = (vld_q << 1) | RD_LAT'(issue);
    seen_fall_d = (state_q == RELOAD) & (seen_fall_q | (wgt_prev_q & ~wgt_bram_load_done));
    wgt_prev_d = wgt_bram_load_done;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gat_layer_q <= 1'b0;
      timeout_q <= 1'b0;
      core_q <= '0;
      wdog_q <= '0;
      rd_addr_q <= '0;
      rd_done_q <= 1'b0;
      out_cnt_q <= '0;
      vld_q <= '0;
      seen_fall_q <= 1'b0;
      wgt_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gat_layer_q <= gat_layer_d;
      timeout_q <= timeout_d;
      core_q <= core_d;
      wdog_q <= wdog_d;
      rd_addr_q <= rd_addr_d;
      rd_done_q <= rd_done_d;
      out_cnt_q <= out_cnt_d;
      vld_q <= vld_d;
      seen_fall_q <= seen_fall_d;
      wgt_prev_q <= wgt_prev_d;
    end
  end
  gat_feat_fifo #(.DEPTH(RD_LAT + 1), .W(NEW_FEATURE_WIDTH), .CW(CW)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (vld_q[RD_LAT-1]),
    .din  (feat_bram_dout),
    .pop  (pop),
    .dout (fifo_dout),
    .count(fifo_cnt),
    .empty(fifo_empty)
  );
  assign {core_h_data_load_done, core_h_node_info_load_done, core_wgt_load_done} = core_q;
  assign gat_layer = gat_layer_q;
  assign sched_layer = gat_layer_q;
  assign sched_timeout = timeout_q;
  assign feat_bram_addrb = rd_addr_q;
  assign feat_tvalid = ~fifo_empty;
  assign feat_tdata = fifo_empty ? '0 : fifo_dout;
  assign feat_tlast = ~fifo_empty & last;
  assign wgt_reload_req = state_q == RELOAD;
  assign sched_busy = state_q != IDLE && state_q != DONE;
  assign sched_done = state_q == DONE;
endmodule

// File: tb/tb_gat_layer_scheduler.sv
// tb_gat_layer_scheduler: table-driven flag gating, random-backpressure stream checks against
// a BRAM content model, reload/timeout/reset sequences.
module tb_gat_layer_scheduler;
  localparam int NS = 5, NO = 4, NF = 3, RL = 2, TW = 8;
  localparam int N0 = NS * NO, N1 = NS * NF;
  localparam int AW = $clog2(NS * NO);
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, hd, nd, wd, gat_ready, feat_tready;
  logic core_h, core_n, core_w, gat_layer, feat_tvalid, feat_tlast, reload_req;
  logic busy, done, timeout, sched_layer;
  logic [AW-1:0] addrb, a1, a2;
  logic [31:0] feat_bram_dout, feat_tdata;
  logic [2:0] core;
  bit bram_layer;
  int tests = 0, fails = 0;
  assign core = {core_h, core_n, core_w};
  function automatic logic [31:0] bram_word(input int unsigned a, input bit l);
    return (a * 32'h9E3779B1) ^ (l ? 32'hC0DE0000 : 32'h00001234) ^ a;
  endfunction
  always @(posedge clk) begin
    a1 <= addrb;
    a2 <= a1;
  end
  assign feat_bram_dout = bram_word(32'(a2), bram_layer);
  gat_layer_scheduler #(
    .NEW_FEATURE_WIDTH(32), .NUM_SUBGRAPHS(NS), .NUM_FEATURE_OUT(NO),
    .NUM_FEATURE_FINAL(NF), .RD_LAT(RL), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .h_data_bram_load_done(hd), .h_node_info_bram_load_done(nd), .wgt_bram_load_done(wd),
    .core_h_data_load_done(core_h), .core_h_node_info_load_done(core_n),
    .core_wgt_load_done(core_w), .gat_layer(gat_layer), .gat_ready(gat_ready),
    .feat_bram_addrb(addrb), .feat_bram_dout(feat_bram_dout), .feat_tdata(feat_tdata),
    .feat_tvalid(feat_tvalid), .feat_tready(feat_tready), .feat_tlast(feat_tlast),
    .wgt_reload_req(reload_req), .sched_busy(busy), .sched_done(done),
    .sched_timeout(timeout), .sched_layer(sched_layer)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic logic [47:0] outs();
    return {core, gat_layer, addrb, feat_tdata, feat_tvalid, feat_tlast, reload_req,
            busy, done, timeout, sched_layer};
  endfunction
  // Called at the negedge where gat_ready was raised while in RUN.
  task automatic drain(input bit l, input int n, input int duty);
    logic [31:0] q[$];
    logic [31:0] held;
    int idx, cyc, first;
    bit stall, rdy;
    for (int i = 0; i < n; i++) q.push_back(bram_word(i, l));
    idx = 0; cyc = 0; first = -1; stall = 0; held = '0;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (first < 0 && feat_tvalid) begin
        first = cyc;
        chk("first_valid_latency", cyc, RL + 2);
      end
      if (stall) begin
        chk("stall_valid", feat_tvalid, 1);
        chk("stall_data", feat_tdata, held);
      end
      rdy = ($urandom_range(0, 99) < duty);
      feat_tready = rdy;
      start = ($urandom_range(0, 15) == 0);
      if (feat_tvalid && rdy) begin
        chk("word", feat_tdata, q.pop_front());
        chk("tlast", feat_tlast, idx == n - 1);
        idx++;
      end
      stall = feat_tvalid && !rdy;
      held = feat_tdata;
    end
    start = 1'b0;
    chk("word_count", idx, n);
    if (duty >= 100) chk("throughput", cyc - first, n - 1);
  endtask
  task automatic start_run();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_status", {busy, done, timeout, gat_layer}, 4'b1000);
  endtask
  task automatic finish_run(input int d0, input int d1);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_run", busy, 1);
    bram_layer = 1'b0;
    gat_ready = 1'b1;
    drain(1'b0, N0, d0);
    @(negedge clk) gat_ready = 1'b0;
    chk("reload_entry", {reload_req, core, feat_tvalid, sched_layer, busy}, 7'b1000001);
    wd = 1'b0;
    repeat (2) @(negedge clk);
    chk("reload_hold", {reload_req, gat_layer}, 2'b10);
    wd = 1'b1;
    @(negedge clk);
    chk("reload_exit", {reload_req, gat_layer, sched_layer, busy}, 4'b0111);
    chk("core_layer1", core, 3'b111);
    bram_layer = 1'b1;
    repeat ($urandom_range(1, 10)) @(negedge clk);
    gat_ready = 1'b1;
    drain(1'b1, N1, d1);
    @(negedge clk) gat_ready = 1'b0;
    chk("done_state", {done, busy, feat_tvalid, core}, 6'b100000);
  endtask
  typedef struct { logic [2:0] host; logic [2:0] core; } vec_t;
  vec_t tbl [6];
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end
  initial begin
    int cnt;
    bit any;
    tbl[0] = '{3'b111, 3'b111};
    tbl[1] = '{3'b011, 3'b011};
    tbl[2] = '{3'b100, 3'b100};
    tbl[3] = '{3'b000, 3'b000};
    tbl[4] = '{3'b101, 3'b101};
    tbl[5] = '{3'b111, 3'b111};
    rst_n = 1'b0; start = 1'b0; hd = 1'b0; nd = 1'b0; wd = 1'b0;
    gat_ready = 1'b0; feat_tready = 1'b0; bram_layer = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1; hd = 1'b1; nd = 1'b1; wd = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", outs(), 0);
    start_run();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      {hd, nd, wd} = tbl[i].host;
      @(negedge clk);
      chk("core_flags", core, tbl[i].core);
    end
    finish_run(100, 30);
    for (int r = 0; r < 3; r++) begin
      start_run();
      finish_run($urandom_range(20, 90), $urandom_range(20, 90));
    end
    nd = 1'b0;
    start_run();
    repeat (5) @(negedge clk);
    chk("wait_load_hold", {core, busy}, 4'b0001);
    nd = 1'b1;
    cnt = 0;
    while (!timeout && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", cnt >= 256 && cnt <= 258, 1);
    chk("timeout_state", {timeout, done, busy, core}, 6'b110000);
    gat_ready = 1'b1;
    feat_tready = 1'b1;
    bram_layer = 1'b0;
    start_run();
    cnt = 0;
    while (!feat_tvalid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    // one WAIT_LOAD cycle, one RUN cycle to take gat_ready, then RD_LAT+1
    chk("preset_ready_latency", cnt, RL + 3);
    chk("preset_first_word", feat_tdata, bram_word(0, 1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_drain", outs(), 0);
    rst_n = 1'b1;
    gat_ready = 1'b0;
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any |= feat_tvalid | busy;
    end
    chk("quiet_after_reset", any, 0);
    start_run();
    finish_run(100, 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gat_layer_scheduler.md
# gat_layer_scheduler

Sequences the two-layer GAT inference run around `gat_top`. It gates the BRAM load-done flags into the core, drives `gat_layer`, and waits for `gat_ready`. It then streams the new-feature BRAM out through a valid/ready port with a backpressure-safe read pipeline, and requests a weight reload between layers. It sits between the register bank / host DMA and `gat_top_wrapper`.

## Interface
Parameters:
- `NEW_FEATURE_WIDTH`, 32, feature word width
- `NUM_SUBGRAPHS`, 2708, nodes whose features are read back
- `NUM_FEATURE_OUT`, 16, layer-0 features per node
- `NUM_FEATURE_FINAL`, 7, layer-1 features per node
- `RD_LAT`, 2, feature-BRAM read latency in cycles
- `TIMEOUT_W`, 24, width of the `gat_ready` watchdog counter
- `FEAT_ADDR_W`, `$clog2(NUM_SUBGRAPHS*NUM_FEATURE_OUT)`, word-address width

Ports (one clock `clk`; reset `rst_n` is synchronous, active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  one-cycle run request from the register bank
- `h_data_bram_load_done`, `h_node_info_bram_load_done`, `wgt_bram_load_done`  in  1 each  host load flags (level)
- `core_h_data_load_done`, `core_h_node_info_load_done`, `core_wgt_load_done`  out  1 each  gated flags to `gat_top`
- `gat_layer`  out  1  current layer to `gat_top`
- `gat_ready`  in  1  core layer-complete (level)
- `feat_bram_addrb`  out  FEAT_ADDR_W  feature-BRAM word address
- `feat_bram_dout`  in  NEW_FEATURE_WIDTH  feature-BRAM read data
- `feat_tdata`  out  NEW_FEATURE_WIDTH  streamed feature word
- `feat_tvalid`  out  1  stream valid
- `feat_tready`  in  1  stream ready
- `feat_tlast`  out  1  marks the last word of a layer
- `wgt_reload_req`  out  1  host must load layer-1 weights
- `sched_busy`, `sched_done`, `sched_timeout`  out  1 each  status
- `sched_layer`  out  1  layer being processed

## Operation
- FSM states: IDLE, WAIT_LOAD, RUN, DRAIN, RELOAD, DONE.
- IDLE -> WAIT_LOAD on `start`. On entry: `gat_layer`=0, watchdog cleared. `start` is ignored in every state except IDLE and DONE.
- WAIT_LOAD: waits until all three host flags are 1, then goes to RUN.
- RUN: the three core flags equal the host flags, registered. The watchdog increments each cycle.
  - `gat_ready`=1 -> DRAIN.
  - Watchdog reaches all-ones -> DONE with `sched_timeout`=1.
- DRAIN: reads word count N = NUM_SUBGRAPHS*NUM_FEATURE_OUT for layer 0, or NUM_SUBGRAPHS*NUM_FEATURE_FINAL for layer 1. Addresses run 0..N-1.
  - A read issues only when `inflight + fifo_count < RD_LAT+1`.
  - Returned data enters an output FIFO of depth RD_LAT+1.
  - FIFO head drives `feat_tdata` / `feat_tvalid`.
  - `feat_tlast`=1 on word N-1.
  - The state exits when word N-1 is accepted (`tvalid & tready`).
- After DRAIN, layer 0 -> RELOAD. The core flags drop to 0 and `wgt_reload_req`=1.
- RELOAD: waits for a falling then rising edge of `wgt_bram_load_done`. It then sets `gat_layer`=1, clears `wgt_reload_req`, and enters RUN. The H flags are reused.
- After DRAIN, layer 1 -> DONE.
- DONE: `sched_done`=1, core flags=0. A new `start` re-enters WAIT_LOAD and clears done/timeout.
- `sched_busy`=1 in every state except IDLE and DONE.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Reset mid-run aborts immediately. No stream words are emitted after reset.
- Core flags lag the host flags by 1 cycle.
- First `feat_tvalid` appears RD_LAT+1 cycles after DRAIN entry.
- With `feat_tready` held at 1, throughput is 1 word per cycle.
- Backpressure: `feat_tdata` is stable while `tvalid & !tready`. No word is dropped or duplicated.
- FIFO push and pop in the same cycle leaves the count unchanged.
- A `gat_ready` that is already high on RUN entry is taken 1 cycle later.
- The watchdog uses saturating compare and does not wrap.

## Structure
- Shared package `gat_pkg` holds:
  - enum `sched_state_t`
  - word-count constants per layer
- Sub-module `gat_feat_fifo` (depth RD_LAT+1, width NEW_FEATURE_WIDTH) provides count, push, and pop.

## Test plan
- Flags preset, `start`, `gat_ready` at cycle 20, `tready`=1: exactly 43328 layer-0 words in address order, `tlast` on word 43327, then `wgt_reload_req`=1.
- Random `tready` at 30% duty during DRAIN: stream matches the BRAM model word-for-word, and data is stable under stall.
- RELOAD: toggle `wgt_bram_load_done` 1->0->1: `gat_layer`=1, then 18956 words, then `sched_done`=1.
- `gat_ready` never asserted, TIMEOUT_W=8: `sched_timeout`=1 after 255 RUN cycles, and the core flags are 0.
- Assert `rst_n`=0 in mid-DRAIN: next cycle all outputs are 0 and the state is IDLE.
- `start` while busy: ignored, and the word count is unchanged.
